// File: rtl/inst_fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory handshake toward imem, word/PC delivery toward decode.
interface inst_fetch_unit_if #(
  parameter int ADDR_W = 32
) ();
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic              stall;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic [31:0]       exInst;
  logic [ADDR_W-1:0] PCNI;
  logic              write;

  modport master (
    output imem_req, imem_addr, exInst, PCNI, write,
    input  imem_ack, imem_rdata, stall, redirect, redirect_pc
  );
  modport slave (
    input  imem_req, imem_addr, exInst, PCNI, write,
    output imem_ack, imem_rdata, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: one-outstanding imem reads into a small FIFO, delivered to decode
// with the next-word PC; redirect flushes and drains any read already in flight.
module inst_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic               clk,
  input logic               rst,
  inst_fetch_unit_if.master bus
);
  localparam int             PW   = $clog2(DEPTH);
  localparam logic [PW:0]    FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_drain_addr;
  logic [PW:0]       r_count;
  logic [PW-1:0]     r_wp;
  logic [PW-1:0]     r_rp;
  logic [31:0]       r_word [DEPTH];
  logic [ADDR_W-1:0] r_addr [DEPTH];

  logic              w_nonempty;
  logic              w_push;
  logic              w_pop;
  logic [PW:0]       w_count_nxt;

  assign w_nonempty  = (r_count != '0);
  assign w_push      = (r_state == S_REQ) & bus.imem_ack & ~bus.redirect;
  assign w_pop       = w_nonempty & ~bus.stall & ~bus.redirect;
  assign w_count_nxt = r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);

  // The drained read keeps its own address so a redirect can retarget fetch_pc immediately.
  assign bus.imem_req  = (r_state == S_REQ) | (r_state == S_DRAIN);
  assign bus.imem_addr = (r_state == S_DRAIN) ? r_drain_addr : r_fetch_pc;

  assign bus.write  = w_pop;
  assign bus.exInst = w_nonempty ? r_word[r_rp] : '0;
  assign bus.PCNI   = w_nonempty ? r_addr[r_rp] + ADDR_W'(4) : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_fetch_pc   <= RESET_PC;
      r_drain_addr <= RESET_PC;
      r_count      <= '0;
      r_wp         <= '0;
      r_rp         <= '0;
    end else if (bus.redirect) begin
      r_count    <= '0;
      r_wp       <= '0;
      r_rp       <= '0;
      r_fetch_pc <= bus.redirect_pc & ~ADDR_W'(3);
      case (r_state)
        S_REQ: begin
          if (bus.imem_ack) begin
            r_state <= S_IDLE;
          end else begin
            r_state      <= S_DRAIN;
            r_drain_addr <= r_fetch_pc;
          end
        end
        S_DRAIN: if (bus.imem_ack) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end else begin
      r_count <= w_count_nxt;
      if (w_push) r_wp <= r_wp + PW'(1);
      if (w_pop)  r_rp <= r_rp + PW'(1);
      case (r_state)
        S_IDLE: if (r_count < FULL) r_state <= S_REQ;
        S_REQ: begin
          if (bus.imem_ack) begin
            r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
            r_state    <= (w_count_nxt < FULL) ? S_REQ : S_IDLE;
          end
        end
        S_DRAIN: if (bus.imem_ack) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Storage needs no reset: head outputs are gated by the count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_word[r_wp] <= bus.imem_rdata;
      r_addr[r_wp] <= r_fetch_pc;
    end
  end
endmodule
